// File: rtl/ge_op_sequencer.sv
// Programmable multi-cycle sequencer for the 4-register, 16-bit evolved datapath.
// Seeds r0..r3 from the operands, runs one stored instruction per clock, returns r3..r0.
module ge_op_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_wdata,
    input  logic          len_we,
    input  logic [AW:0]   len_wdata,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   a1,
    input  logic [15:0]   a0,
    input  logic [15:0]   b1,
    input  logic [15:0]   b0,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   y3,
    output logic [15:0]   y2,
    output logic [15:0]   y1,
    output logic [15:0]   y0,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and y* hold until out_ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW:0]   r_len;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_reg [4];
    logic [15:0]   r_a0, r_a1, r_b0, r_b1;

    logic [7:0]    w_instr;
    logic [2:0]    w_op;
    logic [1:0]    w_dst;
    logic [2:0]    w_src;
    logic [15:0]   w_src_val;
    logic [15:0]   w_dst_val;
    logic [15:0]   w_result;
    logic          w_last;
    logic [AW:0]   w_len_clamped;

    always_comb begin
        w_instr   = r_mem[r_pc];
        w_op      = w_instr[7:5];
        w_dst     = w_instr[4:3];
        w_src     = w_instr[2:0];
        w_dst_val = r_reg[w_dst];
        w_src_val = '0;
        case (w_src)
            3'd0:    w_src_val = r_reg[0];
            3'd1:    w_src_val = r_reg[1];
            3'd2:    w_src_val = r_reg[2];
            3'd3:    w_src_val = r_reg[3];
            3'd4:    w_src_val = r_a0;
            3'd5:    w_src_val = r_a1;
            3'd6:    w_src_val = r_b0;
            default: w_src_val = r_b1;
        endcase
        w_result = '0;
        case (w_op)
            3'd0:    w_result = w_src_val;
            3'd1:    w_result = w_dst_val | w_src_val;
            3'd2:    w_result = w_dst_val & w_src_val;
            3'd3:    w_result = w_dst_val ^ w_src_val;
            3'd4:    w_result = (w_src_val == 16'h0000) ? 16'h0001 : 16'h0000;
            3'd5:    w_result = ~w_src_val;
            3'd6:    w_result = w_dst_val + w_src_val;
            default: w_result = w_dst_val - w_src_val;
        endcase
        w_last        = ({1'b0, r_pc} == (r_len - 1'b1));
        w_len_clamped = (len_wdata > LEN_MAX) ? LEN_MAX : len_wdata;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next_state = (r_len == '0) ? S_DONE : S_EXEC;
            S_EXEC: if (w_last) w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Config writes are honoured only while idle; an accept in the same cycle
    // still uses the old length because r_len is read before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc  <= '0;
            r_len <= '0;
            r_a0  <= '0;
            r_a1  <= '0;
            r_b0  <= '0;
            r_b1  <= '0;
            for (int i = 0; i < 4; i++) r_reg[i] <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (prog_we) r_mem[prog_addr] <= prog_wdata;
                    if (len_we)  r_len <= w_len_clamped;
                    if (in_valid) begin
                        r_a0     <= a0;
                        r_a1     <= a1;
                        r_b0     <= b0;
                        r_b1     <= b1;
                        r_reg[0] <= a0;
                        r_reg[1] <= a1;
                        r_reg[2] <= b0;
                        r_reg[3] <= b1;
                        r_pc     <= '0;
                    end
                end
                S_EXEC: begin
                    r_reg[w_dst] <= w_result;
                    r_pc         <= r_pc + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;
    assign y0 = r_reg[0];
    assign y1 = r_reg[1];
    assign y2 = r_reg[2];
    assign y3 = r_reg[3];

endmodule

// File: tb/tb_ge_op_sequencer.sv
// Directed bench for ge_op_sequencer: reference model plus expected-result queue,
// checked with immediate assertions.
module tb_ge_op_sequencer;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic clk;
  logic rst_n;
  logic prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0] prog_wdata;
  logic len_we;
  logic [AW:0] len_wdata;
  logic in_valid;
  logic in_ready;
  logic [15:0] a1, a0, b1, b0;
  logic out_valid;
  logic out_ready;
  logic [15:0] y3, y2, y1, y0;
  logic busy;
  logic [1:0] dbg_state;

  ge_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .len_we(len_we), .len_wdata(len_wdata),
    .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .out_valid(out_valid), .out_ready(out_ready),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  // reference model state mirrors what the bench has written while idle
  logic [7:0] m_mem [DEPTH];
  int m_len = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [15:0] ma0, input logic [15:0] ma1,
                                        input logic [15:0] mb0, input logic [15:0] mb1);
    logic [15:0] r [4];
    logic [15:0] s;
    logic [15:0] d;
    logic [7:0] ins;
    r[0] = ma0; r[1] = ma1; r[2] = mb0; r[3] = mb1;
    for (int i = 0; i < m_len; i++) begin
      ins = m_mem[i];
      case (ins[2:0])
        3'd4: s = ma0;
        3'd5: s = ma1;
        3'd6: s = mb0;
        3'd7: s = mb1;
        default: s = r[ins[1:0]];
      endcase
      d = r[ins[4:3]];
      case (ins[7:5])
        3'd0: d = s;
        3'd1: d = d | s;
        3'd2: d = d & s;
        3'd3: d = d ^ s;
        3'd4: d = (s == 16'd0) ? 16'd1 : 16'd0;
        3'd5: d = ~s;
        3'd6: d = d + s;
        default: d = d - s;
      endcase
      r[ins[4:3]] = d;
    end
    return {r[3], r[2], r[1], r[0]};
  endfunction

  // driver tasks
  task automatic wr_prog(input int addr, input logic [7:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_wdata = data;
    @(negedge clk);
    prog_we = 1'b0;
    m_mem[addr] = data;
  endtask

  task automatic wr_len(input int len);
    @(negedge clk);
    len_we = 1'b1; len_wdata = (AW+1)'(len);
    @(negedge clk);
    len_we = 1'b0;
    m_len = (len > DEPTH) ? DEPTH : len;
  endtask

  // present operands while idle; returns at the negedge just after the accept edge
  task automatic accept(input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [63:0] exp);
    @(negedge clk);
    a0 = v0; a1 = v1; b0 = w0; b1 = w1; in_valid = 1'b1;
    chk("in_ready_at_accept", in_ready, 1);
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(lat));
    chk("out_valid", out_valid, 1);
  endtask

  task automatic check_out(input string tag);
    logic [63:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk(tag, {y3, y2, y1, y0}, e);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  task automatic run(input logic [15:0] v0, input logic [15:0] v1,
                     input logic [15:0] w0, input logic [15:0] w1,
                     input logic [63:0] exp, input int lat, input string tag);
    accept(v0, v1, w0, w1, exp);
    wait_out(lat);
    check_out(tag);
    release_out();
  endtask

  localparam logic [63:0] EXP1 = {16'h000E, 16'h000F, 16'h0FF0, 16'h0000};

  initial begin
    logic [15:0] r0v, r1v, r2v, r3v;
    int rl;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    len_we = 1'b0; len_wdata = '0; in_valid = 1'b0; out_ready = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_y", {y3, y2, y1, y0}, 64'd0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);

    // directed program 1
    wr_prog(0, 8'h2F); wr_prog(1, 8'h98); wr_prog(2, 8'h7E); wr_len(3);
    run(16'h0000, 16'h0F00, 16'h000F, 16'h00F0, EXP1, 3, "prog1_y");

    // wrap-around ADD/SUB
    wr_prog(0, 8'hC1); wr_prog(1, 8'hF3); wr_len(2);
    run(16'hFFFF, 16'h0001, 16'h0000, 16'h0001,
        {16'h0001, 16'hFFFF, 16'h0001, 16'h0000}, 2, "wrap_y");

    // zero-length program returns seeds
    wr_len(0);
    r0v = 16'($urandom_range(0, 65535)); r1v = 16'($urandom_range(0, 65535));
    r2v = 16'($urandom_range(0, 65535)); r3v = 16'($urandom_range(0, 65535));
    run(r0v, r1v, r2v, r3v, {r3v, r2v, r1v, r0v}, 0, "len0_y");

    // oversize length clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) wr_prog(i, 8'($urandom_range(0, 255)));
    wr_len(DEPTH + 5);
    r0v = 16'($urandom_range(0, 65535)); r1v = 16'($urandom_range(0, 65535));
    r2v = 16'($urandom_range(0, 65535)); r3v = 16'($urandom_range(0, 65535));
    run(r0v, r1v, r2v, r3v, model(r0v, r1v, r2v, r3v), DEPTH, "clamp_y");

    // random programs of random length
    for (int t = 0; t < 4; t++) begin
      rl = $urandom_range(1, 8);
      for (int i = 0; i < rl; i++) wr_prog(i, 8'($urandom_range(0, 255)));
      wr_len(rl);
      r0v = 16'($urandom_range(0, 65535)); r1v = 16'($urandom_range(0, 65535));
      r2v = 16'($urandom_range(0, 65535)); r3v = 16'($urandom_range(0, 65535));
      run(r0v, r1v, r2v, r3v, model(r0v, r1v, r2v, r3v), rl, "random_y");
    end

    // backpressure, dropped DONE-state write, back-to-back accept
    wr_prog(0, 8'h2F); wr_prog(1, 8'h98); wr_prog(2, 8'h7E); wr_len(3);
    accept(16'h0000, 16'h0F00, 16'h000F, 16'h00F0, EXP1);
    wait_out(3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_y_stable", {y3, y2, y1, y0}, EXP1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      if (i == 4) begin
        prog_we = 1'b1; prog_addr = '0; prog_wdata = 8'hFF;
      end else begin
        prog_we = 1'b0;
      end
      @(negedge clk);
    end
    prog_we = 1'b0;
    check_out("bp_y");
    a0 = 16'h0000; a1 = 16'h0F00; b0 = 16'h000F; b1 = 16'h00F0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(EXP1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle_out_valid", out_valid, 0);
    chk("b2b_idle_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepted_busy", busy, 1);
    wait_out(3);
    check_out("b2b_y");
    release_out();

    // reset in the middle of a run
    for (int i = 0; i < 8; i++) wr_prog(i, 8'($urandom_range(0, 255)));
    wr_len(8);
    @(negedge clk);
    a0 = 16'h1234; a1 = 16'h5678; b0 = 16'h9ABC; b1 = 16'hDEF0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_y", {y3, y2, y1, y0}, 64'd0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_len = 0;
    r0v = 16'hA5A5; r1v = 16'h5A5A; r2v = 16'h0F0F; r3v = 16'hF0F0;
    run(r0v, r1v, r2v, r3v, {r3v, r2v, r1v, r0v}, 0, "rst_len_cleared_y");
    wr_len(1);
    run(r0v, r1v, r2v, r3v, model(r0v, r1v, r2v, r3v), 1, "rst_mem_cleared_y");

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
